// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    // FETCH: issuing requests; FLUSH: draining responses that a redirect made stale.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // Layout of one buffered instruction; the FIFO stores {pc, instr} in this order.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and a registered (no bypass) head.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop; full/empty requests are ignored.
    assign do_push = push && !flush && (count_reg != CNT_W'(DEPTH));
    assign do_pop  = pop  && !flush && (count_reg != '0);

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head_data  = head_valid ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited memory requests, in-order responses,
// a buffer of {pc, instr} toward decode, and redirect flushing.
module fetch_unit import fetch_pkg::*; #(
    parameter int               ADDR_W   = FETCH_ADDR_W,
    parameter int               DATA_W   = FETCH_DATA_W,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]  discard_reg, discard_next;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  pcq_count;
    logic              pcq_valid;
    logic [ADDR_W-1:0] pcq_pc;
    logic [ADDR_W+DATA_W-1:0] head_entry;

    logic              grant;
    logic              resp;
    logic              resp_live;
    logic              resp_keep;
    logic              instr_pop;
    logic [CNT_W:0]    credit_used;

    // Handshake decode: a request is only offered while fetching, not redirecting,
    // and while buffered plus in-flight words leave room in the FIFO.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
        mem_req_o   = !reset_i && (state_reg == FETCH) && !redirect_i
                      && (credit_used < (CNT_W+1)'(DEPTH));
        grant       = mem_req_o && mem_gnt_i;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp        = mem_rvalid_i && (outstanding_reg != '0);
        resp_live   = resp && (discard_reg == '0);
        resp_keep   = resp_live && !redirect_i && pcq_valid;
        instr_pop   = instr_valid_o && instr_ready_i;
    end

    // Next-state logic: PC advance, in-flight accounting, redirect and drain.
    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        discard_next     = discard_reg;
        outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(resp);
        if (grant) begin
            fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
        end
        if (redirect_i) begin
            // Everything still in flight after this cycle becomes stale.
            fetch_pc_next = redirect_pc_i;
            discard_next  = outstanding_next;
            state_next    = (outstanding_next != '0) ? FLUSH : FETCH;
        end else if (resp && (discard_reg != '0)) begin
            discard_next = discard_reg - 1'b1;
            if (discard_reg == CNT_W'(1)) begin
                state_next = FETCH;
            end
        end else if ((state_reg == FLUSH) && (discard_reg == '0)) begin
            state_next = FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_reg       <= FETCH;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    assign mem_addr_o = fetch_pc_reg;

    // PCs of live in-flight requests, consumed in order as their data returns.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk        (clk),
        .rst        (reset_i),
        .push       (grant),
        .push_data  (fetch_pc_reg),
        .pop        (resp_live),
        .flush      (redirect_i),
        .count      (pcq_count),
        .head_valid (pcq_valid),
        .head_data  (pcq_pc)
    );

    // Instruction buffer toward decode.
    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk        (clk),
        .rst        (reset_i),
        .push       (resp_keep),
        .push_data  ({pcq_pc, mem_rdata_i}),
        .pop        (instr_pop),
        .flush      (redirect_i),
        .count      (fifo_count),
        .head_valid (instr_valid_o),
        .head_data  (head_entry)
    );

    assign instr_pc_o = head_entry[ADDR_W+DATA_W-1:DATA_W];
    assign instr_o    = head_entry[DATA_W-1:0];

    // Protocol and bookkeeping invariants.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset_i)
        !(mem_rvalid_i && (outstanding_reg == '0)));
    a_credit_bound: assert property (@(posedge clk) disable iff (reset_i)
        (credit_used <= (CNT_W+1)'(DEPTH)) && (pcq_count == outstanding_reg - discard_reg));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              redirect_i = 1'b0;
    logic [ADDR_W-1:0] redirect_pc_i = '0;
    logic              instr_valid_o;
    logic [DATA_W-1:0] instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i = 1'b0;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mem_rsp_t    pend[$];
    exp_t        sb[$];
    logic [31:0] popped[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          lat;
    int          ngrant;
    int          n0;
    logic        gnt_en, ready_en, redir;
    logic [31:0] redir_pc;
    logic [31:0] exp_addr;
    logic        s_req, s_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hold reset for two cycles, check reset outputs, release on a falling edge.
    task automatic do_reset(input int l);
        reset_i = 1'b1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        gnt_en = 1'b0; ready_en = 1'b0; redir = 1'b0; redir_pc = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req",   64'(mem_req_o),     64'd0);
        check_eq("rst_addr",  64'(mem_addr_o),    64'd0);
        check_eq("rst_valid", 64'(instr_valid_o), 64'd0);
        check_eq("rst_instr", 64'(instr_o),       64'd0);
        check_eq("rst_pc",    64'(instr_pc_o),    64'd0);
        pend.delete(); sb.delete(); popped.delete();
        exp_addr = '0; lat = l; ngrant = 0; cyc = 0;
        reset_i = 1'b0;
    endtask

    // One clock cycle: drive memory response and controls, score handshakes.
    task automatic step();
        exp_t e;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].addr + 32'h100;
            pend.delete(0);
        end
        mem_gnt_i = gnt_en; instr_ready_i = ready_en;
        redirect_i = redir; redirect_pc_i = redir_pc;
        #1;
        s_req   = mem_req_o;
        s_valid = instr_valid_o;
        if (mem_req_o) check_eq("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
        if (redir) begin
            sb.delete();
            exp_addr = redir_pc;
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                pend.push_back('{addr: mem_addr_o, due: cyc + lat});
                sb.push_back('{pc: exp_addr, instr: exp_addr + 32'h100});
                exp_addr = exp_addr + 32'd1;
                ngrant++;
            end
            if (instr_valid_o && instr_ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", 64'(instr_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("instr_pc", 64'(instr_pc_o), 64'(e.pc));
                    check_eq("instr",    64'(instr_o),    64'(e.instr));
                    popped.push_back(instr_pc_o);
                    $display("[TB] cyc=%0d pop pc=%h instr=%h", cyc, instr_pc_o, instr_o);
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1;
        // Streaming with 1-cycle memory.
        do_reset(1);
        gnt_en = 1'b1; ready_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq($sformatf("t1_valid_c%0d", i), 64'(s_valid), 64'(i >= 2));
        end
        check_eq("t1_grants", 64'(ngrant), 64'd12);
        check_eq("t1_pops",   64'(popped.size()), 64'd10);

        // Backpressure fills exactly DEPTH credits.
        do_reset(1);
        gnt_en = 1'b1; ready_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("t2_grants", 64'(ngrant), 64'(DEPTH));
        check_eq("t2_req_off", 64'(s_req), 64'd0);
        ready_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("t2_npop_ge5", 64'(popped.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) check_eq($sformatf("t2_order%0d", k), 64'(popped[k]), 64'(k));

        // Redirect with two requests in flight at latency 3.
        do_reset(3);
        gnt_en = 1'b1; ready_en = 1'b1;
        step(); step();
        gnt_en = 1'b0; redir = 1'b1; redir_pc = 32'h40;
        step();
        check_eq("t3_req_redir", 64'(s_req), 64'd0);
        redir = 1'b0; gnt_en = 1'b1;
        step(); check_eq("t3_req_flush0", 64'(s_req), 64'd0);
        step(); check_eq("t3_req_flush1", 64'(s_req), 64'd0);
        step(); check_eq("t3_req_resume", 64'(s_req), 64'd1);
        for (int i = 0; i < 12; i++) step();
        check_eq("t3_first_pc", 64'(popped[0]), 64'h40);

        // Redirect coinciding with a response and a pop.
        do_reset(1);
        gnt_en = 1'b1; ready_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        redir = 1'b1; redir_pc = 32'h80;
        step();
        check_eq("t4_req_redir", 64'(s_req), 64'd0);
        check_eq("t4_valid_redir", 64'(s_valid), 64'd1);
        redir = 1'b0;
        n0 = popped.size();
        step();
        check_eq("t4_fifo_empty", 64'(s_valid), 64'd0);
        check_eq("t4_req_next", 64'(s_req), 64'd1);
        for (int i = 0; i < 8; i++) step();
        check_eq("t4_first_pc", 64'(popped[n0]), 64'h80);

        // PC wrap at the top of the address space.
        do_reset(1);
        gnt_en = 1'b1; ready_en = 1'b1;
        step(); step();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
        step();
        redir = 1'b0;
        n0 = popped.size();
        for (int i = 0; i < 8; i++) step();
        check_eq("t5_pc_top",  64'(popped[n0]),   64'hFFFF_FFFF);
        check_eq("t5_pc_wrap", 64'(popped[n0+1]), 64'h0);

        // Asynchronous reset mid-burst with two requests outstanding.
        do_reset(3);
        gnt_en = 1'b1; ready_en = 1'b1;
        step(); step();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #2;
        check_eq("t6_pre_req",  64'(mem_req_o),  64'd1);
        check_eq("t6_pre_addr", 64'(mem_addr_o), 64'd2);
        reset_i = 1'b1;
        #1;
        check_eq("t6_async_req",   64'(mem_req_o),     64'd0);
        check_eq("t6_async_addr",  64'(mem_addr_o),    64'd0);
        check_eq("t6_async_valid", 64'(instr_valid_o), 64'd0);
        check_eq("t6_async_instr", 64'(instr_o),       64'd0);
        check_eq("t6_async_pc",    64'(instr_pc_o),    64'd0);
        @(negedge clk);
        do_reset(1);
        gnt_en = 1'b1; ready_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_regrant", 64'(ngrant > 0), 64'd1);
        check_eq("t6_first_pc", 64'(popped[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
